shift_seq_ctrl: RTL and testbench

//   Sequencer directly upstream of the 8-bit universal shift register.
//   - Accepts one byte command: data, shift direction, fill bit, shift count.
//   - Drives the register's mode select, parallel-load bus and serial input.
//   - Sequence per command: one parallel load, then N shifts, then a one-cycle done pulse.

---
 rtl/shift_seq_ctrl.sv | 103 ++++++++++
 tb/tb_shift_seq_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - command sequencer feeding an 8-bit universal shift register
module shift_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             dir,
    input  logic             fill,
    input  logic [CNT_W-1:0] count,
    output logic [1:0]       s,
    output logic [WIDTH-1:0] i,
    output logic             r,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam logic [1:0] S_HOLD  = 2'b00;
    localparam logic [1:0] S_UP    = 2'b01;
    localparam logic [1:0] S_DOWN  = 2'b10;
    localparam logic [1:0] S_LOAD  = 2'b11;

    state_t           state, state_next;
    logic [CNT_W-1:0] remaining;
    logic             dir_q, fill_q;
    logic             accept;

    logic [1:0]       s_next;
    logic             r_next, busy_next, done_next, ready_next;

    assign accept = start && ready && (state == IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = LOAD;
            LOAD:    state_next = (remaining == '0) ? DONE : SHIFT;
            SHIFT:   if (remaining == CNT_W'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they settle
    // right after the rising edge, half a cycle ahead of the register's sample.
    always_comb begin
        s_next     = S_HOLD;
        r_next     = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        ready_next = 1'b0;
        case (state_next)
            IDLE:  ready_next = 1'b1;
            LOAD: begin
                s_next    = S_LOAD;
                busy_next = 1'b1;
            end
            SHIFT: begin
                s_next    = dir_q ? S_DOWN : S_UP;
                r_next    = fill_q;
                busy_next = 1'b1;
            end
            DONE:  done_next = 1'b1;
            default: ready_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            dir_q     <= 1'b0;
            fill_q    <= 1'b0;
            s         <= S_HOLD;
            i         <= '0;
            r         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ready     <= 1'b1;
        end else begin
            state <= state_next;
            s     <= s_next;
            r     <= r_next;
            busy  <= busy_next;
            done  <= done_next;
            ready <= ready_next;
            if (accept) begin
                i         <= data_in;
                dir_q     <= dir;
                fill_q    <= fill;
                remaining <= count;
            end else if (state == SHIFT) begin
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - directed self-checking bench for shift_seq_ctrl
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       ready;
    logic [7:0] data_in;
    logic       dir;
    logic       fill;
    logic [3:0] count;
    logic [1:0] s;
    logic [7:0] i;
    logic       r;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;

    logic [7:0] q = 8'h00;

    shift_seq_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .ready(ready),
        .data_in(data_in), .dir(dir), .fill(fill), .count(count),
        .s(s), .i(i), .r(r), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Universal shift register downstream, sampling on the falling edge
    always @(negedge clk) begin
        case (s)
            2'b01: q <= {q[6:0], r};
            2'b10: q <= {r, q[7:1]};
            2'b11: q <= i;
            default: q <= q;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic [7:0] d, input logic dr, input logic fl,
                           input logic [3:0] cnt, input logic intrude, input logic [7:0] exp_q);
        start = 1'b1; data_in = d; dir = dr; fill = fl; count = cnt;
        step();
        start = 1'b0; data_in = 8'h00; dir = 1'b0; fill = 1'b0; count = 4'd0;
        check("load_s", 32'(s), 32'd3);
        check("load_i", 32'(i), 32'(d));
        check("load_busy", 32'(busy), 32'd1);
        check("load_ready", 32'(ready), 32'd0);
        for (int k = 0; k < int'(cnt); k++) begin
            if (intrude && k == 0) begin
                start = 1'b1; data_in = ~d; dir = ~dr; fill = ~fl; count = 4'd0;
            end
            step();
            start = 1'b0;
            check("shift_s", 32'(s), dr ? 32'd2 : 32'd1);
            check("shift_r", 32'(r), 32'(fl));
            check("shift_busy", 32'(busy), 32'd1);
            check("shift_done", 32'(done), 32'd0);
            check("shift_ready", 32'(ready), 32'd0);
        end
        step();
        check("done_pulse", 32'(done), 32'd1);
        check("done_s", 32'(s), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        check("done_ready", 32'(ready), 32'd0);
        check("reg_value", 32'(q), 32'(exp_q));
        step();
        check("idle_done", 32'(done), 32'd0);
        check("idle_ready", 32'(ready), 32'd1);
        check("idle_i_hold", 32'(i), 32'(d));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; data_in = 8'h00; dir = 1'b0; fill = 1'b0; count = 4'd0;
        step();
        step();
        check("rst_s", 32'(s), 32'd0);
        check("rst_i", 32'(i), 32'd0);
        check("rst_r", 32'(r), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        reset = 1'b0;
        step();

        run_cmd(8'hA5, 1'b0, 1'b0, 4'd3, 1'b0, 8'h28);
        run_cmd(8'h81, 1'b1, 1'b1, 4'd2, 1'b0, 8'hE0);
        run_cmd(8'h3C, 1'b0, 1'b1, 4'd0, 1'b0, 8'h3C);
        run_cmd(8'h0F, 1'b0, 1'b1, 4'd2, 1'b1, 8'h3F);
        run_cmd(8'h5A, 1'b1, 1'b0, 4'd10, 1'b0, 8'h00);

        // Abort during the second shift cycle of a count=5 command
        start = 1'b1; data_in = 8'h55; dir = 1'b0; fill = 1'b0; count = 4'd5;
        step();
        start = 1'b0;
        step();
        check("abort_shift1", 32'(s), 32'd1);
        step();
        check("abort_shift2", 32'(s), 32'd1);
        reset = 1'b1;
        step();
        check("abort_s", 32'(s), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_ready", 32'(ready), 32'd1);
        reset = 1'b0;
        step();
        check("abort_no_done", 32'(done), 32'd0);

        // start coinciding with reset is dropped
        reset = 1'b1; start = 1'b1; data_in = 8'hFF; count = 4'd1;
        step();
        reset = 1'b0; start = 1'b0;
        check("rst_start_s", 32'(s), 32'd0);
        check("rst_start_i", 32'(i), 32'd0);
        step();
        check("rst_start_idle_s", 32'(s), 32'd0);
        check("rst_start_idle_busy", 32'(busy), 32'd0);

        run_cmd(8'h01, 1'b0, 1'b1, 4'd1, 1'b0, 8'h03);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
